inst_fetch_resp: RTL and testbench
==================================

Name: inst_fetch_resp

Overview:
Fetch-side responder for the PC generator. It accepts the fetch address and enable the PC generator issues each cycle, runs one read on the instruction memory bus (req/gnt, then rvalid), and returns the instruction with its address to the IF/ID stage. It raises a stall request while a fetch is outstanding, discards in-flight data on a branch flush, and reports bus errors, timeouts and misaligned fetches.

Parameters:
ADDR_W, 32, fetch address width (matches InstAddrBus)
DATA_W, 32, instruction width
TIMEOUT_CYC, 16, cycles allowed in WAIT or DROP without m_rvalid_i before a timeout error is reported
NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction is present

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc_i  in  ADDR_W  fetch address from the PC generator
ce_i  in  1  fetch enable from the PC generator
flush_i  in  1  branch or redirect taken; kill the current fetch
stalled_i  in  5  pipeline stall vector; bit 1 = IF/ID stalled
inst_o  out  DATA_W  fetched instruction
inst_addr_o  out  ADDR_W  address of inst_o
inst_valid_o  out  1  inst_o is valid
stallreq_o  out  1  fetch outstanding; stall the PC generator and front end
fetch_err_o  out  1  one-cycle pulse: misaligned fetch, bus error or timeout
m_req_o  out  1  bus read request
m_addr_o  out  ADDR_W  bus read address
m_gnt_i  in  1  bus grant
m_rvalid_i  in  1  read data valid
m_rdata_i  in  DATA_W  read data
m_err_i  in  1  bus error, qualified by m_rvalid_i

Behaviour:
- Reset, synchronous on rst=1 at the clock edge, with priority over everything else:
  - state IDLE
  - m_req_o=0, m_addr_o=0
  - inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0
  - fetch_err_o=0, timeout counter=0
- Reset mid-transaction: any response still arriving afterwards is ignored; m_rvalid_i in IDLE has no effect.
- FSM states: IDLE, REQ, WAIT, DROP, HOLD. Only one transaction is ever outstanding.
- IDLE:
  - On ce_i=1, flush_i=0, pc_i[1:0]=0: latch m_addr_o<=pc_i, set m_req_o<=1, go to REQ.
  - If pc_i[1:0]!=0: issue no bus request, pulse fetch_err_o next cycle, inst_valid_o=0, stay in IDLE.
- REQ:
  - m_req_o and m_addr_o are held stable until m_gnt_i=1.
  - On grant: m_req_o<=0 and go to WAIT.
  - flush_i=1 without grant: withdraw the request (m_req_o<=0) and go to IDLE.
  - flush_i=1 with grant in the same cycle: go to DROP.
- WAIT, on m_rvalid_i=1:
  - m_err_i=0: inst_o<=m_rdata_i, inst_addr_o<=m_addr_o, inst_valid_o<=1. Next state is HOLD if stalled_i[1]=1, else IDLE.
  - m_err_i=1: inst_valid_o<=0, inst_o<=NOP_INST, pulse fetch_err_o, go to IDLE.
- WAIT with flush_i=1 and no m_rvalid_i: go to DROP.
- WAIT with flush_i=1 and m_rvalid_i=1 in the same cycle: discard the data and go to IDLE.
- DROP: wait for m_rvalid_i, discard it, go to IDLE. No output update and no error, even if m_err_i=1.
- HOLD:
  - inst_o, inst_addr_o and inst_valid_o are held while stalled_i[1]=1.
  - When stalled_i[1]=0: inst_valid_o<=0, go to IDLE.
  - flush_i=1: inst_valid_o<=0, go to IDLE.
- inst_valid_o:
  - It is a one-cycle pulse unless extended by HOLD.
  - When the FSM returns to IDLE with valid data, inst_valid_o stays 1 for that one cycle; a new ce_i can be accepted in the same cycle.
- Flush effect on output: flush_i=1 clears inst_valid_o on the next edge in every state.
- Timeout:
  - The counter is reset on entry to WAIT or DROP and increments each cycle m_rvalid_i=0.
  - On reaching TIMEOUT_CYC-1: pulse fetch_err_o (WAIT only; DROP times out silently) and go to IDLE.
  - The counter saturates; it never wraps.
- stallreq_o (combinational) = (state is REQ, WAIT or DROP) OR (state is IDLE AND ce_i=1 AND flush_i=0 AND pc_i[1:0]=0). It is 0 in HOLD.
- Minimum latency: ce_i sampled at cycle 0 → m_req_o at 1 → gnt at 1 → rvalid at 2 → inst_valid_o=1 at 3.
- Back-to-back fetches: one fetch completes every 3 cycles when grant and rvalid arrive with zero wait states.

Decomposition:
- The following belong in yadan_defs.v:
  - NOP encoding
  - FSM state localparams (3-bit)
  - the IF/ID stall bit index (1)
  - InstAddrBus/InstBus widths
- The timeout counter goes in a sub-module, fetch_timeout_cnt (clear, enable, saturate, expired output). Everything else stays in one module.

Test Plan:
1. Reset, then ce_i=1, pc_i=32'h0000_0100; gnt in cycle 1; rvalid in cycle 2 with rdata 32'h00A0_0093 → at cycle 3: inst_valid_o=1, inst_o=32'h00A0_0093, inst_addr_o=32'h100. stallreq_o=1 in cycles 0–2 and 0 in cycle 3.
2. Grant held off for 3 cycles → m_req_o=1 and m_addr_o stable for 4 cycles. Then complete with stalled_i[1]=1 for 2 cycles → inst_valid_o held 1 for 3 cycles, then 0.
3. flush_i=1 in WAIT; then rvalid 2 cycles later with rdata 32'hDEAD_BEEF → inst_valid_o stays 0, inst_o unchanged, FSM in IDLE; the next fetch to 32'h200 completes normally.
4. m_rvalid_i=1 with m_err_i=1 → fetch_err_o=1 for exactly one cycle, inst_valid_o=0, inst_o=32'h0000_0013.
5. pc_i=32'h0000_0102 with ce_i=1 → m_req_o stays 0 and fetch_err_o pulses once. Separately, no rvalid for 16 cycles in WAIT → fetch_err_o pulse and return to IDLE.
6. rst=1 asserted during WAIT, then rvalid arrives after reset → all outputs at reset values and the late response is ignored.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// inst_fetch_resp_pkg: shared widths, NOP encoding, stall index and FSM states for the fetch responder
package inst_fetch_resp_pkg;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;
  localparam int IFID_STALL_BIT = 1;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_timeout_cnt.sv
// fetch_timeout_cnt: saturating response-wait counter with clear, enable and expired flag
module fetch_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT_CYC - 1);
  always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: single-outstanding instruction fetch over a req/gnt/rvalid bus with flush, hold and error reporting
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int DATA_W = INST_BUS_W,
  parameter int TIMEOUT_CYC = 16,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic [4:0]        stalled_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic              fetch_err_o,
  output logic              m_req_o,
  output logic [ADDR_W-1:0] m_addr_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic              m_err_i
);
  fetch_state_e state_q, state_d;
  logic m_req_q, m_req_d, inst_valid_q, inst_valid_d, fetch_err_q, fetch_err_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d, inst_addr_q, inst_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic if_stall, aligned, accept, to_expired, to_en, to_clr, stall_unused;
  assign if_stall = stalled_i[IFID_STALL_BIT];
  assign stall_unused = ^{stalled_i[4:2], stalled_i[0]};
  assign aligned = pc_i[1:0] == 2'b00;
  assign accept = state_q == S_IDLE && ce_i && !flush_i && aligned;
  assign stallreq_o = state_q == S_REQ || state_q == S_WAIT || state_q == S_DROP || accept;
  assign to_en = (state_q == S_WAIT || state_q == S_DROP) && !m_rvalid_i;
  assign to_clr = state_d != state_q;
  fetch_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_to (
    .clk(clk), .rst(rst), .clr(to_clr), .en(to_en), .expired(to_expired)
  );
  always_comb begin
    state_d = state_q;
    m_req_d = m_req_q;
    m_addr_d = m_addr_q;
    inst_d = inst_q;
    inst_addr_d = inst_addr_q;
    inst_valid_d = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      S_IDLE: if (ce_i && !flush_i) begin
        if (aligned) begin
          m_addr_d = pc_i;
          m_req_d = 1'b1;
          state_d = S_REQ;
        end else fetch_err_d = 1'b1;
      end
      S_REQ: if (flush_i || m_gnt_i) begin
        m_req_d = 1'b0;
        state_d = !m_gnt_i ? S_IDLE : flush_i ? S_DROP : S_WAIT;
      end
      S_WAIT: if (m_rvalid_i) begin
        state_d = S_IDLE;
        if (!flush_i) begin
          inst_d = m_err_i ? NOP_INST : m_rdata_i;
          fetch_err_d = m_err_i;
          inst_valid_d = !m_err_i;
          if (!m_err_i) begin
            inst_addr_d = m_addr_q;
            state_d = if_stall ? S_HOLD : S_IDLE;
          end
        end
      end else if (flush_i) state_d = S_DROP;
      else if (to_expired) begin
        fetch_err_d = 1'b1;
        state_d = S_IDLE;
      end
      // flushed data and silent timeouts both just return to idle
      S_DROP: if (m_rvalid_i || to_expired) state_d = S_IDLE;
      S_HOLD: begin
        inst_valid_d = if_stall && !flush_i;
        state_d = inst_valid_d ? S_HOLD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_req_q <= 1'b0;
      m_addr_q <= '0;
      inst_q <= NOP_INST;
      inst_addr_q <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_req_q <= m_req_d;
      m_addr_q <= m_addr_d;
      inst_q <= inst_d;
      inst_addr_q <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  assign inst_o = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign fetch_err_o = fetch_err_q;
  assign m_req_o = m_req_q;
  assign m_addr_o = m_addr_q;
endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb_inst_fetch_resp: directed plus random stimulus checked against a transaction-level fetch model
module tb_inst_fetch_resp;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst, ce_i, flush_i, m_gnt_i, m_rvalid_i, m_err_i;
  logic [31:0] pc_i, m_rdata_i;
  logic [4:0] stalled_i;
  logic [31:0] inst_o, inst_addr_o, m_addr_o;
  logic inst_valid_o, stallreq_o, fetch_err_o, m_req_o;
  int n_chk = 0, n_err = 0;
  bit req_p, in_fl, disc, hold, e_valid, e_err;
  int age;
  logic [31:0] e_addr, e_inst, e_iaddr;

  inst_fetch_resp dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i), .stalled_i(stalled_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o),
    .fetch_err_o(fetch_err_o), .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_gnt_i(m_gnt_i),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_err_i(m_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // a fetch is outstanding while the request is pending or data is in flight
  function automatic bit exp_stall();
    return req_p || in_fl || (!hold && ce_i && !flush_i && pc_i[1:0] == 2'b00);
  endfunction

  function automatic void model_step();
    e_valid = 0;
    e_err = 0;
    if (rst) begin
      req_p = 0; in_fl = 0; disc = 0; hold = 0; age = 0;
      e_addr = 0; e_inst = NOP; e_iaddr = 0;
    end else if (req_p) begin
      if (m_gnt_i) begin
        req_p = 0; in_fl = 1; disc = flush_i; age = 0;
      end else if (flush_i) req_p = 0;
    end else if (in_fl) begin
      if (m_rvalid_i) begin
        in_fl = 0;
        if (!disc && !flush_i) begin
          if (m_err_i) begin
            e_err = 1; e_inst = NOP;
          end else begin
            e_inst = m_rdata_i; e_iaddr = e_addr; e_valid = 1; hold = stalled_i[1];
          end
        end
      end else if (flush_i && !disc) begin
        disc = 1; age = 0;
      end else if (age == TO - 1) begin
        in_fl = 0; e_err = !disc;
      end else age++;
    end else if (hold) begin
      if (stalled_i[1] && !flush_i) e_valid = 1;
      else hold = 0;
    end else if (ce_i && !flush_i) begin
      if (pc_i[1:0] == 2'b00) begin
        req_p = 1; e_addr = pc_i;
      end else e_err = 1;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    chk("inst", inst_o, e_inst);
    chk("inst_addr", inst_addr_o, e_iaddr);
    chk("inst_valid", inst_valid_o, e_valid);
    chk("fetch_err", fetch_err_o, e_err);
    chk("m_req", m_req_o, req_p);
    chk("m_addr", m_addr_o, e_addr);
    chk("stallreq", stallreq_o, exp_stall());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; ce_i = 0; flush_i = 0; pc_i = 0; stalled_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_err_i = 0; m_rdata_i = 0;
  endtask

  task automatic start_fetch(logic [31:0] pc);
    ce_i = 1; pc_i = pc; step();
    ce_i = 0; m_gnt_i = 1; step();
    m_gnt_i = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(posedge clk);
    model_step();
    #1;
    step();
    chk("rst_inst", inst_o, NOP);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_req", m_req_o, 0);
    rst = 0;
    // zero-wait-state fetch
    ce_i = 1; pc_i = 32'h100; step();
    ce_i = 0; m_gnt_i = 1; step();
    m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h00A0_0093; step();
    m_rvalid_i = 0;
    chk("t1_inst", inst_o, 32'h00A0_0093);
    chk("t1_valid", inst_valid_o, 1);
    chk("t1_addr", inst_addr_o, 32'h100);
    chk("t1_stall", stallreq_o, 0);
    step();
    chk("t1_pulse", inst_valid_o, 0);
    // delayed grant then a held result
    ce_i = 1; pc_i = 32'h104; step();
    ce_i = 0;
    repeat (3) begin
      chk("t2_req", m_req_o, 1);
      chk("t2_addr", m_addr_o, 32'h104);
      step();
    end
    m_gnt_i = 1; step();
    m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h0010_0113; stalled_i = 5'b00010; step();
    m_rvalid_i = 0;
    repeat (2) begin
      chk("t2_hold", inst_valid_o, 1);
      step();
    end
    chk("t2_hold", inst_valid_o, 1);
    stalled_i = 0; step();
    chk("t2_release", inst_valid_o, 0);
    // flush while waiting discards the late data
    start_fetch(32'h108);
    flush_i = 1; step();
    flush_i = 0; step();
    m_rvalid_i = 1; m_rdata_i = 32'hDEAD_BEEF; step();
    m_rvalid_i = 0;
    chk("t3_valid", inst_valid_o, 0);
    chk("t3_inst", inst_o, 32'h0010_0113);
    start_fetch(32'h200);
    m_rvalid_i = 1; m_rdata_i = 32'h1234_5678; step();
    m_rvalid_i = 0;
    chk("t3_next_addr", inst_addr_o, 32'h200);
    chk("t3_next_valid", inst_valid_o, 1);
    // bus error
    start_fetch(32'h10C);
    m_rvalid_i = 1; m_err_i = 1; step();
    m_rvalid_i = 0; m_err_i = 0;
    chk("t4_err", fetch_err_o, 1);
    chk("t4_valid", inst_valid_o, 0);
    chk("t4_inst", inst_o, NOP);
    step();
    chk("t4_err_pulse", fetch_err_o, 0);
    // misaligned fetch
    ce_i = 1; pc_i = 32'h102; step();
    ce_i = 0;
    chk("t5_mis_req", m_req_o, 0);
    chk("t5_mis_err", fetch_err_o, 1);
    step();
    chk("t5_mis_pulse", fetch_err_o, 0);
    // timeout in WAIT
    start_fetch(32'h110);
    repeat (TO - 1) begin
      chk("t5_to_early", fetch_err_o, 0);
      step();
    end
    step();
    chk("t5_to_err", fetch_err_o, 1);
    chk("t5_to_idle", stallreq_o, 0);
    step();
    // reset during WAIT, late response ignored
    start_fetch(32'h114);
    rst = 1; step();
    rst = 0; m_rvalid_i = 1; m_rdata_i = 32'hDEAD_BEEF; step();
    m_rvalid_i = 0;
    chk("t6_valid", inst_valid_o, 0);
    chk("t6_inst", inst_o, NOP);
    chk("t6_addr", inst_addr_o, 0);
    chk("t6_maddr", m_addr_o, 0);
    step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      ce_i = $urandom_range(0, 9) < 8;
      pc_i = $urandom;
      if ($urandom_range(0, 9) != 0) pc_i[1:0] = 2'b00;
      flush_i = $urandom_range(0, 9) == 0;
      stalled_i = 5'($urandom);
      m_gnt_i = $urandom_range(0, 1) == 1;
      m_rvalid_i = (i % 200 > 175) ? 1'b0 : $urandom_range(0, 2) == 0;
      m_err_i = $urandom_range(0, 4) == 0;
      m_rdata_i = $urandom;
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
